modulation_az_sequencer: RTL and testbench
==========================================

Name: modulation_az_sequencer

Overview:
- Auto-zero modulation controller for the DMM front end.
- Sequences the precharge switch (sw_pc_ctl) and the azmux between the signal (HI) and the zero reference (LO).
- Triggers one ADC conversion per phase via the adc_measure_start/adc_measure_done handshake, repeating HI/LO pairs while run is high.
- Sits between the top-level control registers and the ADC integrator controller.

Parameters:
- PRECHARGE_N, 10000: settle length in clk cycles; each settle phase lasts PRECHARGE_N+1 cycles (500us at 20MHz).
- AZMUX_HI, 4'b1000: azmux code that selects the signal (S1).
- TIMEOUT_N, 24'd2000000: ADC-done watchdog limit in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock, 20MHz.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  enables cycling; sampled in IDLE and CHECK only.
- azmux_lo_val  in  4  azmux code for the LO (zero) phase; latched in IDLE and CHECK.
- adc_measure_done  in  1  ADC conversion complete, level or pulse.
- sw_pc_ctl  out  1  precharge switch: 1=SIGNAL, 0=BOOT.
- azmux  out  4  azmux select code.
- adc_measure_start  out  1  single-cycle ADC trigger.
- sample_hi  out  1  1 while the current/last conversion is the HI phase.
- led0  out  1  toggles once per completed HI/LO pair.
- monitor  out  2  debug: [0]=settle phase active, [1]=ADC wait active.
- cycle_count  out  16  completed HI/LO pairs, wraps at 65535->0.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (reset_n=0, async, takes effect immediately, including mid-conversion):
  - state=IDLE, sw_pc_ctl=0, azmux=4'b0000, adc_measure_start=0.
  - sample_hi=0, led0=0, monitor=0, cycle_count=0, err_timeout=0, down-counter=0.
- Down-counter: 32-bit. Loaded on phase entry, decremented every clk. Wait states exit on the cycle count==0 is seen.
- IDLE: azmux=0, sw_pc_ctl=0. If run=1, latch azmux_lo_val into lo_reg and go to BOOT.
- BOOT: sw_pc_ctl<=0, load PRECHARGE_N, monitor[0]<=1 -> BOOT_W.
- BOOT_W: when count==0 -> PRECHARGE.
- PRECHARGE: azmux<=AZMUX_HI, load PRECHARGE_N -> PRECHARGE_W.
- PRECHARGE_W: when count==0 -> HI_START.
- HI_START: sw_pc_ctl<=1, sample_hi<=1, monitor<=2'b10, adc_measure_start<=1 -> HI_WAIT.
- HI_WAIT: adc_measure_start<=0. When adc_measure_done=1 -> PROTECT.
- PROTECT: sw_pc_ctl<=0, load PRECHARGE_N, monitor<=2'b01 -> PROTECT_W.
- PROTECT_W: when count==0 -> LO_START.
- LO_START: azmux<=lo_reg, sample_hi<=0, monitor<=2'b10, adc_measure_start<=1 -> LO_WAIT.
- LO_WAIT: adc_measure_start<=0. When done=1 -> CHECK.
- CHECK: cycle_count<=cycle_count+1 (wraps), led0<=~led0, monitor<=0.
  - run=1: re-latch lo_reg, go to PRECHARGE. The BOOT settle is skipped because sw_pc_ctl is already 0.
  - run=0: go to IDLE.
- adc_measure_start is high for exactly one cycle per conversion: the cycle after entering the *_START state.
- adc_measure_done is ignored outside HI_WAIT/LO_WAIT. A done already high on the first WAIT cycle is accepted (ADC guarantees done low before start).
- run dropping mid-sequence has no effect until CHECK: the pair always completes.
- Unused state encodings -> IDLE on the next clk.

Optional Feature:
- MODULATION_AZ_TIMEOUT_EN defined:
  - A counter runs in HI_WAIT/LO_WAIT.
  - If done is not seen within TIMEOUT_N cycles: err_timeout<=1 (sticky until reset), sw_pc_ctl<=0, azmux<=0, state->IDLE.
  - IDLE does not leave while err_timeout=1.
- Macro undefined: no watchdog logic, err_timeout tied 0, WAIT states wait indefinitely.

Test Plan:
- Bench setup: PRECHARGE_N=4, ADC model asserts done 10 cycles after start.
- Basic pair: run=1, azmux_lo_val=4'b1001.
  - azmux 0->1000 after BOOT (5 cycles).
  - start pulses once with sw_pc_ctl=1, azmux=1000, sample_hi=1.
  - Then sw_pc_ctl=0 for 5 cycles, then azmux=1001 with a second start pulse.
  - cycle_count=1 and led0=1 after CHECK.
- Continuous run: run held 1 for 3 pairs -> cycle_count=3, led0=1, exactly 6 start pulses, each 1 cycle wide. No BOOT after the first pair.
- Run drop: deassert run during HI_WAIT -> LO phase still executes, cycle_count increments, then IDLE with azmux=0, sw_pc_ctl=0.
- Async reset: pulse reset_n low during LO_WAIT with no clk edge -> all outputs at reset values immediately. Restarts from BOOT when released with run=1.
- Wrap: force cycle_count=16'hFFFF, complete one pair -> cycle_count=0.
- Timeout (MODULATION_AZ_TIMEOUT_EN, TIMEOUT_N=50): ADC never asserts done -> err_timeout=1 at cycle 51 of HI_WAIT, then IDLE. Held in IDLE despite run=1 until reset_n pulse.

Source files
------------

// File: rtl/modulation_az_sequencer_if.sv
// Interface for the auto-zero modulation sequencer.
// It bundles the register-side controls, the ADC start/done handshake and the front-end switch and status outputs.
// The master modport is the sequencer side. The slave modport is the register block, the ADC and the front end.
interface modulation_az_sequencer_if;
    logic        run;
    logic [3:0]  azmux_lo_val;
    logic        adc_measure_done;
    logic        sw_pc_ctl;
    logic [3:0]  azmux;
    logic        adc_measure_start;
    logic        sample_hi;
    logic        led0;
    logic [1:0]  monitor;
    logic [15:0] cycle_count;
    logic        err_timeout;

    modport master (
        input  run, azmux_lo_val, adc_measure_done,
        output sw_pc_ctl, azmux, adc_measure_start, sample_hi,
        output led0, monitor, cycle_count, err_timeout
    );

    modport slave (
        output run, azmux_lo_val, adc_measure_done,
        input  sw_pc_ctl, azmux, adc_measure_start, sample_hi,
        input  led0, monitor, cycle_count, err_timeout
    );
endinterface

// File: rtl/modulation_az_sequencer.sv
// Auto-zero modulation controller for the DMM front end.
// The sequencer runs the precharge switch and the azmux through HI (signal) and LO (zero) phases.
// It fires one ADC conversion per phase and repeats HI/LO pairs while run stays high.
// Optional ADC-done watchdog: define MODULATION_AZ_TIMEOUT_EN. Without it, err_timeout is tied low
// and the wait states wait indefinitely.
module modulation_az_sequencer #(
    parameter int unsigned PRECHARGE_N = 10000,
    parameter logic [3:0]  AZMUX_HI    = 4'b1000,
    parameter logic [23:0] TIMEOUT_N   = 24'd2000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    modulation_az_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        BOOT        = 4'd1,
        BOOT_W      = 4'd2,
        PRECHARGE   = 4'd3,
        PRECHARGE_W = 4'd4,
        HI_START    = 4'd5,
        HI_WAIT     = 4'd6,
        PROTECT     = 4'd7,
        PROTECT_W   = 4'd8,
        LO_START    = 4'd9,
        LO_WAIT     = 4'd10,
        CHECK       = 4'd11
    } state_t;

    localparam logic [31:0] SETTLE_LOAD = 32'(PRECHARGE_N);

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [3:0]  lo_reg_q, lo_reg_d;
    logic        sw_pc_ctl_q, sw_pc_ctl_d;
    logic [3:0]  azmux_q, azmux_d;
    logic        start_q, start_d;
    logic        sample_hi_q, sample_hi_d;
    logic        led0_q, led0_d;
    logic [1:0]  monitor_q, monitor_d;
    logic [15:0] cycle_count_q, cycle_count_d;
    logic        idle_hold;

`ifdef MODULATION_AZ_TIMEOUT_EN
    logic [23:0] wd_count_q, wd_count_d;
    logic        err_timeout_q, err_timeout_d;

    assign idle_hold       = err_timeout_q;
    assign bus.err_timeout = err_timeout_q;
`else
    logic [23:0] timeout_unused;

    assign timeout_unused  = TIMEOUT_N;
    assign idle_hold       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.sw_pc_ctl         = sw_pc_ctl_q;
    assign bus.azmux             = azmux_q;
    assign bus.adc_measure_start = start_q;
    assign bus.sample_hi         = sample_hi_q;
    assign bus.led0              = led0_q;
    assign bus.monitor           = monitor_q;
    assign bus.cycle_count       = cycle_count_q;

    // State and output registers; reset is asynchronous and immediately parks every output at its safe value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            count_q       <= 32'd0;
            lo_reg_q      <= 4'd0;
            sw_pc_ctl_q   <= 1'b0;
            azmux_q       <= 4'd0;
            start_q       <= 1'b0;
            sample_hi_q   <= 1'b0;
            led0_q        <= 1'b0;
            monitor_q     <= 2'b00;
            cycle_count_q <= 16'd0;
`ifdef MODULATION_AZ_TIMEOUT_EN
            wd_count_q    <= 24'd0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            lo_reg_q      <= lo_reg_d;
            sw_pc_ctl_q   <= sw_pc_ctl_d;
            azmux_q       <= azmux_d;
            start_q       <= start_d;
            sample_hi_q   <= sample_hi_d;
            led0_q        <= led0_d;
            monitor_q     <= monitor_d;
            cycle_count_q <= cycle_count_d;
`ifdef MODULATION_AZ_TIMEOUT_EN
            wd_count_q    <= wd_count_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    // Next-state and next-output logic. The start pulse defaults low so that it lasts only one cycle.
    always_comb begin
        state_d       = state_q;
        count_d       = (count_q != 32'd0) ? (count_q - 32'd1) : 32'd0;
        lo_reg_d      = lo_reg_q;
        sw_pc_ctl_d   = sw_pc_ctl_q;
        azmux_d       = azmux_q;
        start_d       = 1'b0;
        sample_hi_d   = sample_hi_q;
        led0_d        = led0_q;
        monitor_d     = monitor_q;
        cycle_count_d = cycle_count_q;
`ifdef MODULATION_AZ_TIMEOUT_EN
        wd_count_d    = 24'd0;
        err_timeout_d = err_timeout_q;
`endif

        case (state_q)
            IDLE: begin
                azmux_d     = 4'd0;
                sw_pc_ctl_d = 1'b0;
                if (bus.run && !idle_hold) begin
                    lo_reg_d = bus.azmux_lo_val;
                    state_d  = BOOT;
                end
            end
            BOOT: begin
                sw_pc_ctl_d = 1'b0;
                count_d     = SETTLE_LOAD;
                monitor_d   = {monitor_q[1], 1'b1};
                state_d     = BOOT_W;
            end
            BOOT_W: begin
                if (count_q == 32'd0) begin
                    state_d = PRECHARGE;
                end
            end
            PRECHARGE: begin
                azmux_d = AZMUX_HI;
                count_d = SETTLE_LOAD;
                state_d = PRECHARGE_W;
            end
            PRECHARGE_W: begin
                if (count_q == 32'd0) begin
                    state_d = HI_START;
                end
            end
            HI_START: begin
                sw_pc_ctl_d = 1'b1;
                sample_hi_d = 1'b1;
                monitor_d   = 2'b10;
                start_d     = 1'b1;
                state_d     = HI_WAIT;
            end
            HI_WAIT: begin
                if (bus.adc_measure_done) begin
                    state_d = PROTECT;
                end
            end
            PROTECT: begin
                sw_pc_ctl_d = 1'b0;
                count_d     = SETTLE_LOAD;
                monitor_d   = 2'b01;
                state_d     = PROTECT_W;
            end
            PROTECT_W: begin
                if (count_q == 32'd0) begin
                    state_d = LO_START;
                end
            end
            LO_START: begin
                azmux_d     = lo_reg_q;
                sample_hi_d = 1'b0;
                monitor_d   = 2'b10;
                start_d     = 1'b1;
                state_d     = LO_WAIT;
            end
            LO_WAIT: begin
                if (bus.adc_measure_done) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cycle_count_d = cycle_count_q + 16'd1;
                led0_d        = ~led0_q;
                monitor_d     = 2'b00;
                if (bus.run) begin
                    // sw_pc_ctl is already in BOOT, so the next pair goes straight to the HI settle.
                    lo_reg_d = bus.azmux_lo_val;
                    state_d  = PRECHARGE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef MODULATION_AZ_TIMEOUT_EN
        // Watchdog: count the cycles spent waiting for done. On expiry, park the front end and latch the error.
        if ((state_q == HI_WAIT) || (state_q == LO_WAIT)) begin
            if (!bus.adc_measure_done) begin
                if (wd_count_q == TIMEOUT_N) begin
                    err_timeout_d = 1'b1;
                    sw_pc_ctl_d   = 1'b0;
                    azmux_d       = 4'd0;
                    state_d       = IDLE;
                end else begin
                    wd_count_d = wd_count_q + 24'd1;
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_modulation_az_sequencer.sv
// Self-checking bench for modulation_az_sequencer (PRECHARGE_N=4, ADC model answers ~10 cycles after start).
// Timeout checks are compiled in when MODULATION_AZ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_modulation_az_sequencer;

    localparam int unsigned PRE_N   = 4;
    localparam int          ADC_LAT = 10;
    localparam logic [3:0]  AZ_HI   = 4'b1000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    modulation_az_sequencer_if bus ();

    modulation_az_sequencer #(
        .PRECHARGE_N(PRE_N),
        .AZMUX_HI   (AZ_HI),
        .TIMEOUT_N  (24'd50)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sw;
        logic [3:0] azmux;
        logic       sample_hi;
        logic [1:0] monitor;
    } pulse_t;

    typedef struct {
        logic [3:0]  lo;
        int          pairs;
        logic [15:0] exp_count;
        logic        exp_led;
    } vec_t;

    pulse_t      sb_q[$];
    int          checks      = 0;
    int          errors      = 0;
    int          start_count = 0;
    bit          adc_enable  = 1'b1;
    logic        prev_start  = 1'b0;
    logic [15:0] prev_count  = 16'd0;
    bit          boot_check  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] lo, input logic run);
        @(posedge clk);
        #3;
        bus.azmux_lo_val = lo;
        bus.run          = run;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushPair(input logic [3:0] lo);
        sb_q.push_back('{sw: 1'b1, azmux: AZ_HI, sample_hi: 1'b1, monitor: 2'b10});
        sb_q.push_back('{sw: 1'b0, azmux: lo, sample_hi: 1'b0, monitor: 2'b10});
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        tick(3);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic waitStarts(input int target, input int budget, input string name);
        int n = 0;
        while (start_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (start_count < target) checkOutput(name, 32'(start_count), 32'(target));
    endtask

    task automatic waitCount(input logic [15:0] target, input int budget, input string name);
        int n = 0;
        while (bus.cycle_count !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.cycle_count !== target) checkOutput(name, 32'(bus.cycle_count), 32'(target));
    endtask

    // Rising edges from run (or reset release) until azmux shows HI: IDLE, BOOT, 5x BOOT_W, PRECHARGE = 8
    task automatic measureBoot(input string name);
        int lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (bus.azmux !== AZ_HI && lat < 50);
        checkOutput(name, 32'(lat), 32'd8);
    endtask

    task automatic checkIdle(input string tag, input logic [15:0] cnt, input logic led);
        checkOutput({tag, "_count"}, 32'(bus.cycle_count), 32'(cnt));
        checkOutput({tag, "_led0"}, 32'(bus.led0), 32'(led));
        checkOutput({tag, "_azmux"}, 32'(bus.azmux), 32'd0);
        checkOutput({tag, "_sw"}, 32'(bus.sw_pc_ctl), 32'd0);
        checkOutput({tag, "_monitor"}, 32'(bus.monitor), 32'd0);
        checkOutput({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    // ADC model: done pulses for one cycle ADC_LAT cycles after a start is seen
    initial begin
        int adc_cnt = 0;
        bus.adc_measure_done = 1'b0;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (!reset_n) begin
                adc_cnt = 0;
                bus.adc_measure_done = 1'b0;
            end else begin
                bus.adc_measure_done = 1'b0;
                if (bus.adc_measure_start === 1'b1 && adc_enable) begin
                    adc_cnt = ADC_LAT;
                end else if (adc_cnt > 0) begin
                    adc_cnt--;
                    if (adc_cnt == 0) bus.adc_measure_done = 1'b1;
                end
            end
        end
    end

    // Scoreboard and pulse monitor: every start pulse pops one expected front-end state.
    // A pair-count increment with run high must go straight to the HI settle, with no BOOT.
    initial begin
        pulse_t exp;
        forever begin
            @(negedge clk);
            if (boot_check) begin
                checkOutput("no_boot_between_pairs", 32'(bus.azmux), 32'(AZ_HI));
                boot_check = 1'b0;
            end
            if (bus.adc_measure_start === 1'b1) begin
                start_count++;
                checkOutput("start_single_cycle", 32'(prev_start), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_start: pulse %0d with no expected entry", start_count);
                end else begin
                    exp = sb_q.pop_front();
                    checkOutput("pulse_sw_pc_ctl", 32'(bus.sw_pc_ctl), 32'(exp.sw));
                    checkOutput("pulse_azmux", 32'(bus.azmux), 32'(exp.azmux));
                    checkOutput("pulse_sample_hi", 32'(bus.sample_hi), 32'(exp.sample_hi));
                    checkOutput("pulse_monitor", 32'(bus.monitor), 32'(exp.monitor));
                end
            end
            if (reset_n && bus.run === 1'b1 && bus.cycle_count === (prev_count + 16'd1)) boot_check = 1'b1;
            prev_start = bus.adc_measure_start;
            prev_count = bus.cycle_count;
        end
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] time limit");
    end

    initial begin
        vec_t vecs[4];
        int   base;
        int   n;

        vecs[0] = '{lo: 4'b0110, pairs: 3, exp_count: 16'd3, exp_led: 1'b1};
        vecs[1] = '{lo: 4'b0000, pairs: 2, exp_count: 16'd2, exp_led: 1'b0};
        vecs[2] = '{lo: 4'b1111, pairs: 1, exp_count: 16'd1, exp_led: 1'b1};
        vecs[3] = '{lo: 4'b0011, pairs: 4, exp_count: 16'd4, exp_led: 1'b0};

        bus.run          = 1'b0;
        bus.azmux_lo_val = 4'd0;
        tick(3);

        // Reset state
        checkOutput("reset_sw", 32'(bus.sw_pc_ctl), 32'd0);
        checkOutput("reset_azmux", 32'(bus.azmux), 32'd0);
        checkOutput("reset_start", 32'(bus.adc_measure_start), 32'd0);
        checkOutput("reset_sample_hi", 32'(bus.sample_hi), 32'd0);
        checkOutput("reset_led0", 32'(bus.led0), 32'd0);
        checkOutput("reset_monitor", 32'(bus.monitor), 32'd0);
        checkOutput("reset_count", 32'(bus.cycle_count), 32'd0);
        checkOutput("reset_err", 32'(bus.err_timeout), 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick(3);
        checkOutput("idle_no_run_azmux", 32'(bus.azmux), 32'd0);

        // Basic pair: BOOT latency, PROTECT settle, then one completed pair
        $display("[TB] basic pair");
        base = start_count;
        pushPair(4'b1001);
        applyStimulus(4'b1001, 1'b1);
        measureBoot("boot_latency");
        checkOutput("boot_sw", 32'(bus.sw_pc_ctl), 32'd0);
        waitStarts(base + 1, 60, "wait_hi_start");
        applyStimulus(4'b1001, 1'b0);
        n = 0;
        while (bus.sw_pc_ctl !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        // sw low through PROTECT_W (5 cycles) and LO_START (1) before the LO pulse
        n = 0;
        while (bus.adc_measure_start !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkOutput("protect_cycles", 32'(n), 32'd6);
        waitCount(16'd1, 80, "wait_pair1");
        tick(2);
        checkIdle("basic", 16'd1, 1'b1);
        checkOutput("basic_sample_hi", 32'(bus.sample_hi), 32'd0);

        // Table: back-to-back pairs with run dropped during the last HI_WAIT
        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d: lo=%b pairs=%0d", i, vecs[i].lo, vecs[i].pairs);
            doReset();
            base = start_count;
            for (int p = 0; p < vecs[i].pairs; p++) pushPair(vecs[i].lo);
            applyStimulus(vecs[i].lo, 1'b1);
            waitStarts(base + 2 * vecs[i].pairs - 1, vecs[i].pairs * 60 + 40, "wait_last_hi");
            applyStimulus(vecs[i].lo, 1'b0);
            waitCount(vecs[i].exp_count, 80, "wait_pairs_done");
            tick(2);
            checkIdle("vec", vecs[i].exp_count, vecs[i].exp_led);
            checkOutput("vec_start_pulses", 32'(start_count - base), 32'(2 * vecs[i].pairs));
        end

        // Async reset during LO_WAIT, away from any clock edge, then restart through BOOT
        $display("[TB] async reset");
        base = start_count;
        pushPair(4'b0101);
        applyStimulus(4'b0101, 1'b1);
        waitStarts(base + 2, 150, "wait_lo_start");
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset_sw", 32'(bus.sw_pc_ctl), 32'd0);
        checkOutput("areset_azmux", 32'(bus.azmux), 32'd0);
        checkOutput("areset_sample_hi", 32'(bus.sample_hi), 32'd0);
        checkOutput("areset_monitor", 32'(bus.monitor), 32'd0);
        checkOutput("areset_count", 32'(bus.cycle_count), 32'd0);
        checkOutput("areset_start", 32'(bus.adc_measure_start), 32'd0);
        tick(3);
        base = start_count;
        pushPair(4'b0101);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        measureBoot("reboot_latency");
        waitStarts(base + 1, 60, "wait_rehi_start");
        applyStimulus(4'b0101, 1'b0);
        waitCount(16'd1, 80, "wait_repair");
        tick(2);
        checkIdle("restart", 16'd1, 1'b1);

        // Counter wrap from 16'hFFFF; led0 toggles from 1 back to 0
        $display("[TB] wrap");
        force dut.cycle_count_q = 16'hFFFF;
        tick(2);
        release dut.cycle_count_q;
        tick(1);
        checkOutput("wrap_preload", 32'(bus.cycle_count), 32'h0000FFFF);
        base = start_count;
        pushPair(4'b0111);
        applyStimulus(4'b0111, 1'b1);
        waitStarts(base + 1, 60, "wait_wrap_hi");
        applyStimulus(4'b0111, 1'b0);
        waitCount(16'd0, 80, "wait_wrap");
        tick(2);
        checkIdle("wrap", 16'd0, 1'b0);

`ifdef MODULATION_AZ_TIMEOUT_EN
        // Watchdog: done never arrives; the error appears at cycle 51 of HI_WAIT and holds IDLE
        $display("[TB] timeout");
        doReset();
        adc_enable = 1'b0;
        base = start_count;
        sb_q.push_back('{sw: 1'b1, azmux: AZ_HI, sample_hi: 1'b1, monitor: 2'b10});
        applyStimulus(4'b1010, 1'b1);
        n = 0;
        while (bus.adc_measure_start !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'd51);
        checkOutput("timeout_sw", 32'(bus.sw_pc_ctl), 32'd0);
        checkOutput("timeout_azmux", 32'(bus.azmux), 32'd0);
        tick(20);
        checkOutput("timeout_held_starts", 32'(start_count - base), 32'd1);
        checkOutput("timeout_held_azmux", 32'(bus.azmux), 32'd0);
        checkOutput("timeout_sticky", 32'(bus.err_timeout), 32'd1);
        applyStimulus(4'b1010, 1'b0);
        doReset();
        tick(1);
        checkOutput("timeout_cleared", 32'(bus.err_timeout), 32'd0);
        adc_enable = 1'b1;
`else
        checkOutput("err_timeout_tied", 32'(bus.err_timeout), 32'd0);
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
